// File: rtl/dnn_weight_loader_param.sv
// Parametrised DNN weight loader: fetches memory blocks and streams words into per-layer neuron weight registers.
// Latency: start -> mem_req next cycle; mem_ready -> first write_weight next cycle; one weight per cycle after that.
// Backpressure: weight_ready low holds weight_bus and all *_sel outputs stable. Optional checksum: DNN_WLD_CHECKSUM_EN.
module dnn_weight_loader_param #(
   parameter  int WORD_W    = 64,
   parameter  int BLK_WORDS = 8,
   parameter  int N_LAYERS  = 7,
   parameter  int NEURON_W  = 4,
   parameter  int WEIGHT_W  = 7,
   parameter  int ADDR_W    = 32,
   localparam int LSEL_W    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             base_addr,
   input  logic [N_LAYERS*NEURON_W-1:0]  cfg_neurons,
   input  logic [N_LAYERS*WEIGHT_W-1:0]  cfg_weights,
   input  logic [WORD_W-1:0]             exp_sum,
   output logic                          mem_req,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic                          mem_ready,
   input  logic [BLK_WORDS*WORD_W-1:0]   mem_data,
   output logic [WORD_W-1:0]             weight_bus,
   output logic [LSEL_W-1:0]             layer_sel,
   output logic [NEURON_W-1:0]           neuron_sel,
   output logic [WEIGHT_W-1:0]           weight_sel,
   output logic                          write_weight,
   input  logic                          weight_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          sum_err
);
   localparam int WCNT_W = $clog2(BLK_WORDS);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE} state_t;

   state_t                         r_state, w_next;
   logic [N_LAYERS*NEURON_W-1:0]   r_cfg_n;
   logic [N_LAYERS*WEIGHT_W-1:0]   r_cfg_w;
   logic [ADDR_W-1:0]              r_addr;
   logic [BLK_WORDS*WORD_W-1:0]    r_buf;
   logic [WCNT_W-1:0]              r_word;
   logic [WEIGHT_W-1:0]            r_wcnt;
   logic [NEURON_W-1:0]            r_ncnt;
   logic [LSEL_W-1:0]              r_layer;

   logic [N_LAYERS-1:0]            w_lyr_ok, w_in_ok;
   logic                           w_nxt_found, w_in_found;
   logic [LSEL_W-1:0]              w_nxt_layer, w_in_layer;
   logic [NEURON_W-1:0]            w_cur_n;
   logic [WEIGHT_W-1:0]            w_cur_w;
   logic [WORD_W-1:0]              w_word;
   logic                           w_xfer, w_last_w, w_last_n, w_last_word;

   assign w_cur_n     = r_cfg_n[r_layer*NEURON_W +: NEURON_W];
   assign w_cur_w     = r_cfg_w[r_layer*WEIGHT_W +: WEIGHT_W];
   assign w_word      = r_buf[r_word*WORD_W +: WORD_W];
   assign w_xfer      = (r_state == S_WRITE) && weight_ready;
   assign w_last_w    = (r_wcnt == w_cur_w - 1'b1);
   assign w_last_n    = (r_ncnt == w_cur_n - 1'b1);
   assign w_last_word = (r_word == WCNT_W'(BLK_WORDS - 1));

   // A layer is loadable only if it has both neurons and weights; find first (from inputs) and next (from latched cfg)
   always_comb begin
      w_lyr_ok    = '0;
      w_in_ok     = '0;
      w_nxt_found = 1'b0;
      w_nxt_layer = '0;
      w_in_found  = 1'b0;
      w_in_layer  = '0;
      for (int i = 0; i < N_LAYERS; i++) begin
         w_lyr_ok[i] = (|r_cfg_n[i*NEURON_W +: NEURON_W]) && (|r_cfg_w[i*WEIGHT_W +: WEIGHT_W]);
         w_in_ok[i]  = (|cfg_neurons[i*NEURON_W +: NEURON_W]) && (|cfg_weights[i*WEIGHT_W +: WEIGHT_W]);
      end
      // descending scan so the lowest qualifying index wins
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (w_lyr_ok[i] && (i > int'(r_layer))) begin
            w_nxt_found = 1'b1;
            w_nxt_layer = LSEL_W'(i);
         end
         if (w_in_ok[i]) begin
            w_in_found = 1'b1;
            w_in_layer = LSEL_W'(i);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; a neuron always ends its block, so finishing one neuron re-requests
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = w_in_found ? S_REQ : S_DONE;
         S_REQ:   w_next = S_WAIT;
         S_WAIT:  if (mem_ready) w_next = S_WRITE;
         S_WRITE: begin
            if (w_xfer) begin
               if (w_last_w) w_next = (!w_last_n || w_nxt_found) ? S_REQ : S_DONE;
               else if (w_last_word) w_next = S_REQ;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode from state and counters
   always_comb begin
      mem_req      = (r_state == S_REQ);
      write_weight = (r_state == S_WRITE);
      busy         = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_WRITE);
      done         = (r_state == S_DONE);
      weight_bus   = (r_state == S_WRITE) ? w_word : '0;
      mem_addr     = r_addr;
      layer_sel    = r_layer;
      neuron_sel   = r_ncnt;
      weight_sel   = r_wcnt;
   end

   // Configuration latch, block buffer, address and layer/neuron/weight/word counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_n <= '0;
         r_cfg_w <= '0;
         r_addr  <= '0;
         r_buf   <= '0;
         r_word  <= '0;
         r_wcnt  <= '0;
         r_ncnt  <= '0;
         r_layer <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_cfg_n <= cfg_neurons;
               r_cfg_w <= cfg_weights;
               r_addr  <= base_addr;
               r_word  <= '0;
               r_wcnt  <= '0;
               r_ncnt  <= '0;
               r_layer <= w_in_layer;
            end
            S_WAIT: if (mem_ready) begin
               r_buf  <= mem_data;
               r_word <= '0;
               r_addr <= r_addr + 1'b1;
            end
            S_WRITE: if (w_xfer) begin
               if (w_last_w) begin
                  r_wcnt <= '0;
                  if (!w_last_n) begin
                     r_ncnt <= r_ncnt + 1'b1;
                  end else begin
                     r_ncnt <= '0;
                     if (w_nxt_found) r_layer <= w_nxt_layer;
                  end
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
                  r_word <= r_word + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DNN_WLD_CHECKSUM_EN
   logic [WORD_W-1:0] r_sum;
   logic              r_err;

   // Modular sum of accepted words, compared against exp_sum when the load completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else if ((r_state == S_IDLE) && start) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else if (w_xfer) begin
         r_sum <= r_sum + w_word;
      end else if (r_state == S_DONE) begin
         r_err <= (r_sum != exp_sum);
      end
   end

   assign sum_err = r_err;
`else
   logic w_unused_exp_sum;
   assign w_unused_exp_sum = ^exp_sum;
   assign sum_err          = 1'b0;
`endif

endmodule

// File: tb/tb_dnn_weight_loader_param.sv
// Scoreboard bench for dnn_weight_loader_param: a reference model expands each configuration into the
// expected request addresses and weight writes; a memory responder and a write monitor check the DUT
// independently while a random sink applies backpressure.
module tb_dnn_weight_loader_param;
   logic          clk, rst_n, start;
   logic [31:0]   base_addr;
   logic [27:0]   cfg_neurons;
   logic [48:0]   cfg_weights;
   logic [63:0]   exp_sum;
   logic          mem_req, mem_ready;
   logic [31:0]   mem_addr;
   logic [511:0]  mem_data;
   logic [63:0]   weight_bus;
   logic [2:0]    layer_sel;
   logic [3:0]    neuron_sel;
   logic [6:0]    weight_sel;
   logic          write_weight, weight_ready, busy, done, sum_err;

   int            n_vec = 0;
   int            n_err = 0;
   logic [31:0]   salt  = 32'h0;
   logic [77:0]   exp_q[$];
   logic [31:0]   req_q[$];

   dnn_weight_loader_param dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .cfg_neurons(cfg_neurons), .cfg_weights(cfg_weights), .exp_sum(exp_sum),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
      .weight_bus(weight_bus), .layer_sel(layer_sel), .neuron_sel(neuron_sel),
      .weight_sel(weight_sel), .write_weight(write_weight), .weight_ready(weight_ready),
      .busy(busy), .done(done), .sum_err(sum_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [31:0] a, input int k);
      return {a ^ salt, 32'(k + 1)};
   endfunction

   task automatic chk_reset();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_weight_bus", weight_bus, 0);
      chk("rst_layer_sel", layer_sel, 0);
      chk("rst_neuron_sel", neuron_sel, 0);
      chk("rst_weight_sel", weight_sel, 0);
      chk("rst_write_weight", write_weight, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum_err", sum_err, 0);
   endtask

   // Random sink readiness with occasional 4-cycle stalls
   int stall = 0;
   always @(posedge clk) begin
      #1;
      if (stall > 0) begin
         weight_ready = 1'b0;
         stall--;
      end else if ($urandom_range(0, 99) < 8) begin
         weight_ready = 1'b0;
         stall = 3;
      end else begin
         weight_ready = ($urandom_range(0, 99) < 80);
      end
   end

   // Memory responder: checks each request address, sometimes pulses mem_ready with junk during REQ
   initial begin : responder
      logic [31:0] a;
      mem_ready = 1'b0;
      mem_data  = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mem_req) begin
            a = mem_addr;
            if (req_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_req: actual addr=%0h required=no request", a);
            end else begin
               chk("mem_addr", a, req_q.pop_front());
            end
            if ($urandom_range(0, 3) == 0) begin
               mem_ready = 1'b1;
               for (int k = 0; k < 8; k++) mem_data[k*64 +: 64] = {$urandom(), $urandom()};
            end
            @(negedge clk);
            mem_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int k = 0; k < 8; k++) mem_data[k*64 +: 64] = word_of(a, k);
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
         end
      end
   end

   // Write monitor: pops expected writes, checks hold under backpressure and done latency
   int          tcyc = 0;
   int          last_acc = 0;
   bit          acc_vld = 1'b0;
   bit          prev_stall = 1'b0;
   logic [77:0] prev_out = '0;
   always @(negedge clk) begin : monitor
      logic [77:0] cur;
      tcyc++;
      cur = {layer_sel, neuron_sel, weight_sel, weight_bus};
      if (!rst_n) begin
         prev_stall = 1'b0;
         acc_vld    = 1'b0;
      end else begin
         if (write_weight && prev_stall) chk("stall_hold", cur, prev_out);
         if (write_weight && weight_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: actual=%0h required=no write", cur);
            end else begin
               chk("write", cur, exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  last_acc = tcyc;
                  acc_vld  = 1'b1;
               end
            end
         end
         if (done) begin
            if (acc_vld) chk("done_latency", tcyc - last_acc, 1);
            acc_vld = 1'b0;
         end
         prev_stall = write_weight && !weight_ready;
         prev_out   = cur;
      end
   end

   // Reference model + driver for one load; called on a negative edge
   task automatic run_load(input logic [27:0] cn, input logic [48:0] cw, input logic [31:0] base,
                           input bit inject, input bit abort);
      logic [63:0] msum, es, d;
      logic [31:0] a;
      logic [3:0]  n;
      logic [6:0]  w;
      int          blk, cyc, nwr;
      bit          exp_err;
      salt = $urandom();
      msum = '0;
      blk  = 0;
      nwr  = 0;
      for (int L = 0; L < 7; L++) begin
         n = cn[L*4 +: 4];
         w = cw[L*7 +: 7];
         if (n != 0 && w != 0) begin
            for (int nn = 0; nn < int'(n); nn++) begin
               for (int j = 0; j < int'(w); j++) begin
                  if (j % 8 == 0) begin
                     req_q.push_back(base + 32'(blk));
                     blk++;
                  end
                  a = base + 32'(blk - 1);
                  d = word_of(a, j % 8);
                  msum += d;
                  exp_q.push_back({3'(L), 4'(nn), 7'(j), d});
                  nwr++;
               end
            end
         end
      end
      es = ($urandom_range(0, 1) == 1) ? msum : msum + 64'd1;
`ifdef DNN_WLD_CHECKSUM_EN
      exp_err = (msum != es);
`else
      exp_err = 1'b0;
`endif
      start = 1'b1; cfg_neurons = cn; cfg_weights = cw; base_addr = base; exp_sum = es;
      @(negedge clk);
      start = 1'b0;
      chk("sum_err_clear", sum_err, 0);
      if (nwr == 0) begin
         chk("zero_done_cycle1", done, 1);
         chk("zero_no_req", mem_req, 0);
      end else begin
         chk("first_req_cycle1", mem_req, 1);
      end
      cyc = 0;
      while (!done && cyc < 5000) begin
         if (abort && write_weight && cyc > 4) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk_reset();
            exp_q.delete();
            req_q.delete();
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         @(negedge clk);
         cyc++;
         if (inject) begin
            if (cyc == 7 && busy) begin
               start = 1'b1; cfg_neurons = 28'($urandom()); cfg_weights = 49'({$urandom(), $urandom()});
               base_addr = $urandom(); exp_sum = {$urandom(), $urandom()};
            end else begin
               start = 1'b0; cfg_neurons = cn; cfg_weights = cw; base_addr = base; exp_sum = es;
            end
         end
      end
      start = 1'b0;
      if (cyc >= 5000) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: actual=no done after %0d cycles required=done", cyc);
      end
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("sum_err", sum_err, exp_err);
      chk("writes_left", exp_q.size(), 0);
      chk("reqs_left", req_q.size(), 0);
   endtask

   initial begin
      logic [27:0] cn;
      logic [48:0] cw;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; cfg_neurons = '0; cfg_weights = '0; exp_sum = '0;
      weight_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      @(negedge clk);
      // single layer, 1 neuron x 5 weights
      run_load(28'h1, 49'd5, 32'h100, 1'b0, 1'b0);
      // multi-block neuron, 1 x 17, also across the address wrap
      run_load(28'h1, 49'd17, 32'h2000, 1'b0, 1'b0);
      run_load(28'h1, 49'd17, 32'hFFFF_FFFE, 1'b0, 1'b0);
      // layer skip {2x3, 0x4, 1x0, 1x2}
      run_load({12'h0, 4'd1, 4'd1, 4'd0, 4'd2}, {21'h0, 7'd2, 7'd0, 7'd4, 7'd3}, 32'h3000, 1'b0, 1'b0);
      // all-zero configuration
      run_load(28'h0, 49'h0, 32'h4000, 1'b0, 1'b0);
      // start while busy is ignored
      run_load({24'h0, 4'd2}, {42'h0, 7'd20}, 32'h5000, 1'b1, 1'b0);
      // reset during WRITE, then recover
      run_load({24'h0, 4'd2}, {42'h0, 7'd20}, 32'h6000, 1'b0, 1'b1);
      run_load({20'h0, 4'd1, 4'd3}, {35'h0, 7'd9, 7'd8}, 32'h7000, 1'b0, 1'b0);
      // random configurations
      for (int t = 0; t < 25; t++) begin
         for (int L = 0; L < 7; L++) begin
            cn[L*4 +: 4] = 4'($urandom_range(0, 3));
            cw[L*7 +: 7] = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 20));
         end
         run_load(cn, cw, $urandom(), ($urandom_range(0, 3) == 0), 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
